// File: rtl/sprite_pkg.sv
// Shared types and constants for the circle sprite generator.
// Optional outline mode is compiled in with SPRITE_RING_EN.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROW    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int DEF_DIAM = 63;

  function automatic int center(input int diam);
    return (diam - 1) / 2;
  endfunction

  // Wide enough for dx^2 + dy^2 at the sprite corners without truncation.
  function automatic int dist_w(input int diam);
    return 2 * $clog2(diam) + 1;
  endfunction

  localparam int DEF_DIST_W = dist_w(DEF_DIAM);

endpackage

// File: rtl/circle_sprite_gen_if.sv
// Request/status/sprite bundle between the physics core, generator and renderer.
// The ring request line exists only when SPRITE_RING_EN is defined.
interface circle_sprite_gen_if #(
  parameter int SPRITE_DIAM = 63,
  parameter int RAD_W       = 5
);

  logic                                  start;
  logic [RAD_W-1:0]                      radius;
`ifdef SPRITE_RING_EN
  logic                                  ring;
`endif
  logic                                  busy;
  logic                                  done;
  logic                                  sprite_valid;
  logic [SPRITE_DIAM-1:0][SPRITE_DIAM-1:0] sprite;

  modport gen (
    input  start,
    input  radius,
`ifdef SPRITE_RING_EN
    input  ring,
`endif
    output busy,
    output done,
    output sprite_valid,
    output sprite
  );

  modport host (
    output start,
    output radius,
`ifdef SPRITE_RING_EN
    output ring,
`endif
    input  busy,
    input  done,
    input  sprite_valid,
    input  sprite
  );

endinterface

// File: rtl/circle_row_mask.sv
// One row of the circle bitmap: one distance comparator per column.
// With SPRITE_RING_EN an inner bound turns the disc into an outline.
module circle_row_mask
  import sprite_pkg::*;
#(
  parameter int SPRITE_DIAM = DEF_DIAM,
  parameter int IDX_W       = $clog2(SPRITE_DIAM),
  parameter int DIST_W      = dist_w(SPRITE_DIAM)
) (
  input  logic signed [IDX_W:0]   dy,
  input  logic [DIST_W-1:0]       r_sq,
`ifdef SPRITE_RING_EN
  input  logic [DIST_W-1:0]       r_in_sq,
  input  logic                    ring,
`endif
  output logic [SPRITE_DIAM-1:0]  mask
);

  localparam int C = center(SPRITE_DIAM);

  logic [IDX_W:0]      dy_mag;
  logic [DIST_W-1:0]   dy_ext;
  logic [DIST_W-1:0]   dy_sq;

  assign dy_mag = dy[IDX_W] ? $unsigned(-dy) : $unsigned(dy);
  assign dy_ext = DIST_W'(dy_mag);
  assign dy_sq  = dy_ext * dy_ext;

  for (genvar j = 0; j < SPRITE_DIAM; j++) begin : g_col
    localparam int                DX    = j - C;
    localparam logic [DIST_W-1:0] DX_SQ = DIST_W'(DX * DX);
    logic [DIST_W-1:0] dist_sq;
    assign dist_sq = dy_sq + DX_SQ;
`ifdef SPRITE_RING_EN
    assign mask[j] = (dist_sq < r_sq) && (!ring || (dist_sq >= r_in_sq));
`else
    assign mask[j] = (dist_sq < r_sq);
`endif
  end

endmodule

// File: rtl/circle_sprite_gen.sv
// Builds a circle sprite one row per clock into a shadow buffer, then commits it atomically.
// Defining SPRITE_RING_EN adds the ring request and outline mode.
module circle_sprite_gen
  import sprite_pkg::*;
#(
  parameter int SPRITE_DIAM = DEF_DIAM,
  parameter int RAD_W       = 5
) (
  input  logic             clock,
  input  logic             reset_L,
  circle_sprite_gen_if.gen bus
);

  localparam int C      = center(SPRITE_DIAM);
  localparam int IDX_W  = $clog2(SPRITE_DIAM);
  localparam int DIST_W = dist_w(SPRITE_DIAM);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(SPRITE_DIAM - 1);

  state_t state, state_nx;

  logic [IDX_W-1:0]                        row_idx;
  logic [DIST_W-1:0]                       r_eff;
  logic [DIST_W-1:0]                       r_sq, r_sq_nx;
  logic signed [IDX_W:0]                   dy;
  logic [SPRITE_DIAM-1:0]                  row_mask;
  logic [SPRITE_DIAM-1:0][SPRITE_DIAM-1:0] shadow;
  logic [SPRITE_DIAM-1:0][SPRITE_DIAM-1:0] sprite_q;
  logic                                    busy_q, done_q, valid_q;
`ifdef SPRITE_RING_EN
  logic [DIST_W-1:0]                       r_in_sq, r_in_sq_nx;
  logic                                    ring_q;
`endif

  // Clamp before squaring so the latched radius never exceeds the sprite half-width.
  always_comb begin
    r_eff = DIST_W'(bus.radius);
    if (int'(bus.radius) > C) r_eff = DIST_W'(C);
    r_sq_nx = r_eff * r_eff;
`ifdef SPRITE_RING_EN
    r_in_sq_nx = (r_eff == '0) ? '0 : (r_eff - 1'b1) * (r_eff - 1'b1);
`endif
  end

  assign dy = $signed({1'b0, row_idx}) - $signed((IDX_W + 1)'(C));

  circle_row_mask #(
    .SPRITE_DIAM (SPRITE_DIAM),
    .IDX_W       (IDX_W),
    .DIST_W      (DIST_W)
  ) u_row_mask (
    .dy      (dy),
    .r_sq    (r_sq),
`ifdef SPRITE_RING_EN
    .r_in_sq (r_in_sq),
    .ring    (ring_q),
`endif
    .mask    (row_mask)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = ROW;
      ROW:     if (row_idx == LAST_ROW) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      row_idx  <= '0;
      r_sq     <= '0;
      shadow   <= '0;
      sprite_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SPRITE_RING_EN
      r_in_sq  <= '0;
      ring_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (state_nx != IDLE);
      done_q <= (state == COMMIT);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            row_idx <= '0;
            r_sq    <= r_sq_nx;
`ifdef SPRITE_RING_EN
            r_in_sq <= r_in_sq_nx;
            ring_q  <= bus.ring;
`endif
          end
        end
        ROW: begin
          shadow[row_idx] <= row_mask;
          row_idx         <= (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
        end
        COMMIT: begin
          sprite_q <= shadow;
          valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sprite_valid = valid_q;
  assign bus.sprite       = sprite_q;

endmodule

// File: tb/tb_circle_sprite_gen.sv
// Randomised bench for circle_sprite_gen (D=63 and D=7 instances) against an arithmetic pixel model.
// Outline checks are added when SPRITE_RING_EN is defined.
module tb_circle_sprite_gen;

  logic clock   = 1'b0;
  logic reset_L = 1'b1;
  always #5 clock = ~clock;

  circle_sprite_gen_if #(.SPRITE_DIAM(63), .RAD_W(6)) big_if ();
  circle_sprite_gen_if #(.SPRITE_DIAM(7),  .RAD_W(3)) small_if ();

  circle_sprite_gen #(.SPRITE_DIAM(63), .RAD_W(6)) u_big (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (big_if)
  );

  circle_sprite_gen #(.SPRITE_DIAM(7), .RAD_W(3)) u_small (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (small_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int small_done_cnt = 0;

  always @(posedge clock) if (small_if.done === 1'b1) small_done_cnt++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference pixel rule: lit iff (r-1)^2 <= dx^2+dy^2 < r^2 (lower bound only in ring mode).
  function automatic logic [63:0] exp_row(input int diam, input int rad, input bit ring, input int i);
    int c, r, d;
    logic [63:0] m;
    c = (diam - 1) / 2;
    r = (rad > c) ? c : rad;
    m = '0;
    for (int j = 0; j < diam; j++) begin
      d = (j - c) * (j - c) + (i - c) * (i - c);
      m[j] = (d < r * r) && (!ring || d >= (r - 1) * (r - 1));
    end
    return m;
  endfunction

  task automatic big_image(input string tag, input int rad);
    for (int i = 0; i < 63; i++)
      check_val($sformatf("%s_row%0d", tag, i), 64'(big_if.sprite[i]), exp_row(63, rad, 1'b0, i));
  endtask

  task automatic small_image(input string tag, input int rad, input bit ring);
    for (int i = 0; i < 7; i++)
      check_val($sformatf("%s_row%0d", tag, i), 64'(small_if.sprite[i]), exp_row(7, rad, ring, i));
  endtask

  // Called #1 after an edge; returns #1 after the edge at which done is seen.
  task automatic big_run(input int rad, input bit disturb, input int hold_rad, output int n);
    big_if.start  = 1'b1;
    big_if.radius = 6'(rad);
    @(posedge clock); #1;
    big_if.start = 1'b0;
    check_val($sformatf("big_busy_r%0d", rad), 64'(big_if.busy), 64'd1);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
      if (disturb && n == 10) begin
        big_if.radius = 6'($urandom_range(0, 63));
        big_if.start  = 1'b1;
      end else begin
        big_if.start = 1'b0;
      end
      if (hold_rad >= 0 && (n == 30 || n == 63))
        check_val($sformatf("big_hold_n%0d", n), 64'(big_if.sprite[31 - hold_rad / 2]),
                  exp_row(63, hold_rad, 1'b0, 31 - hold_rad / 2));
    end while (big_if.done !== 1'b1 && n < 200);
    big_if.start = 1'b0;
    check_val($sformatf("big_latency_r%0d", rad), 64'(n), 64'd64);
  endtask

  task automatic small_run(input int rad, input bit ring_val, input bit disturb, output int n);
    small_if.start  = 1'b1;
    small_if.radius = 3'(rad);
`ifdef SPRITE_RING_EN
    small_if.ring   = ring_val;
`endif
    @(posedge clock); #1;
    small_if.start = 1'b0;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
      small_if.start = disturb && (n == 4 || n == 7);
`ifdef SPRITE_RING_EN
      small_if.ring = ~ring_val;
`endif
    end while (small_if.done !== 1'b1 && n < 50);
    small_if.start = 1'b0;
    check_val($sformatf("small_latency_r%0d_ring%0d", rad, ring_val), 64'(n), 64'd8);
  endtask

  initial begin
    int n, rad, prev, cnt0;
    bit rg;
    big_if.start    = 1'b0;
    big_if.radius   = '0;
    small_if.start  = 1'b0;
    small_if.radius = '0;
`ifdef SPRITE_RING_EN
    big_if.ring     = 1'b0;
    small_if.ring   = 1'b0;
`endif
    #1 reset_L = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_busy",   64'(big_if.busy), 64'd0);
    check_val("rst_done",   64'(big_if.done), 64'd0);
    check_val("rst_valid",  64'(big_if.sprite_valid), 64'd0);
    check_val("rst_sprite", 64'(|big_if.sprite), 64'd0);
    reset_L = 1'b1;
    @(posedge clock); #1;

    // Legacy ball
    big_run(31, 1'b0, -1, n);
    check_val("r31_valid", 64'(big_if.sprite_valid), 64'd1);
    big_image("r31", 31);
    check_val("r31_row1_cols24_38", 64'(big_if.sprite[1]), ((64'd1 << 15) - 64'd1) << 24);
    check_val("r31_row0",  64'(big_if.sprite[0]),  64'd0);
    check_val("r31_row62", 64'(big_if.sprite[62]), 64'd0);
    @(posedge clock); #1;
    check_val("done_one_cycle", 64'(big_if.done), 64'd0);
    check_val("busy_after",     64'(big_if.busy), 64'd0);

    // Clamp, with a mid-build radius change and ignored start
    big_run(40, 1'b1, 31, n);
    big_image("r40", 31);
    big_run(0, 1'b1, 31, n);
    big_image("r0", 0);
    check_val("r0_valid", 64'(big_if.sprite_valid), 64'd1);

    prev = 0;
    for (int k = 0; k < 3; k++) begin
      rad = $urandom_range(0, 63);
      big_run(rad, 1'b1, prev, n);
      big_image($sformatf("rand%0d_r%0d", k, rad), rad);
      prev = (rad > 31) ? 31 : rad;
    end

    // Back-to-back: second start in the done cycle of the first
    big_run(31, 1'b0, prev, n);
    big_run(5, 1'b0, 31, n);
    big_image("b2b_r5", 5);

    // Reset in the middle of a build
    big_if.start  = 1'b1;
    big_if.radius = 6'd10;
    @(posedge clock); #1;
    big_if.start = 1'b0;
    repeat (20) @(posedge clock);
    #2 reset_L = 1'b0;
    #1;
    check_val("midrst_busy",   64'(big_if.busy), 64'd0);
    check_val("midrst_done",   64'(big_if.done), 64'd0);
    check_val("midrst_valid",  64'(big_if.sprite_valid), 64'd0);
    check_val("midrst_sprite", 64'(|big_if.sprite), 64'd0);
    @(posedge clock); #1;
    reset_L = 1'b1;
    @(posedge clock); #1;
    check_val("postrst_busy", 64'(big_if.busy), 64'd0);
    big_run(7, 1'b0, -1, n);
    big_image("postrst_r7", 7);

    // Small sprite: centre pixel only, starts during build ignored
    cnt0 = small_done_cnt;
    small_run(1, 1'b0, 1'b1, n);
    check_val("small_r1_row3", 64'(small_if.sprite[3]), 64'h8);
    small_image("small_r1", 1, 1'b0);
    repeat (12) @(posedge clock);
    #1;
    check_val("small_done_count", 64'(small_done_cnt - cnt0), 64'd1);
    check_val("small_idle_busy",  64'(small_if.busy), 64'd0);

    for (int k = 0; k < 4; k++) begin
      rad = $urandom_range(0, 7);
`ifdef SPRITE_RING_EN
      rg = 1'($urandom_range(0, 1));
`else
      rg = 1'b0;
`endif
      small_run(rad, rg, 1'b1, n);
      small_image($sformatf("small_rand%0d_r%0d", k, rad), rad, rg);
    end

`ifdef SPRITE_RING_EN
    small_run(3, 1'b1, 1'b0, n);
    check_val("ring_row3",   64'(small_if.sprite[3]), 64'h22);
    check_val("ring_centre", 64'(small_if.sprite[3][3]), 64'd0);
    small_image("ring_r3", 3, 1'b1);
    small_run(1, 1'b1, 1'b0, n);
    small_image("ring_r1", 1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
